stepper_move_controller: RTL



---
 rtl/stepper_move_controller_if.sv | 22 ++
 rtl/stepper_move_controller.sv | 129 ++++++++++++
 2 files changed

// File: rtl/stepper_move_controller_if.sv
// Command/status bundle between the key-mapping stage and the stepper move controller.
// master = command source / observer, slave = controller.
interface stepper_move_controller_if;
  logic       cmdValid;
  logic [3:0] movement;
  logic       stop;
  logic       cmdReady;
  logic [3:0] coils;
  logic       busy;
  logic       done;
  logic [7:0] position;

  modport master (
    output cmdValid, movement, stop,
    input  cmdReady, coils, busy, done, position
  );

  modport slave (
    input  cmdValid, movement, stop,
    output cmdReady, coils, busy, done, position
  );
endinterface

// File: rtl/stepper_move_controller.sv
// One move at a time: full-step coil sequencing at STEP_DIV cycles/step, then a STEP_DIV settle.
// Latency: first step STEP_DIV cycles after accept; cmdReady only in IDLE. Macro STEPPER_HOLD_EN keeps coils energized in IDLE.
module stepper_move_controller #(
  parameter int STEP_DIV = 50000
) (
  input  logic                      i_clk,
  input  logic                      i_resetN,
  stepper_move_controller_if.slave  io_bus
);

  localparam int DW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [DW-1:0] DIV_RELOAD = DW'(STEP_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, SETTLE} state_t;

  state_t        r_state, w_state_n;
  logic [DW-1:0] r_div, w_div_n;
  logic [3:0]    r_rem, w_rem_n;
  logic          r_dir, w_dir_n;
  logic [1:0]    r_phase, w_phase_n;
  logic [7:0]    r_position, w_pos_n;
  logic [3:0]    r_coils, w_coils_n;
  logic          r_busy, r_done, w_done_n;
  logic [3:0]    w_mag;

  function automatic logic [3:0] phase_pattern(input logic [1:0] ph);
    case (ph)
      2'd0:    phase_pattern = 4'b0011;
      2'd1:    phase_pattern = 4'b0110;
      2'd2:    phase_pattern = 4'b1100;
      default: phase_pattern = 4'b1001;
    endcase
  endfunction

  // -8 negates to 4'b1000, which read unsigned is the required magnitude 8.
  assign w_mag = io_bus.movement[3] ? 4'(~io_bus.movement + 4'd1) : io_bus.movement;

  always_comb begin
    w_state_n = r_state;
    w_div_n   = r_div;
    w_rem_n   = r_rem;
    w_dir_n   = r_dir;
    w_phase_n = r_phase;
    w_pos_n   = r_position;
    w_done_n  = 1'b0;
    case (r_state)
      IDLE: begin
        if (io_bus.cmdValid) begin
          if (io_bus.movement == 4'd0) begin
            w_done_n = 1'b1;
          end else begin
            w_state_n = RUN;
            w_div_n   = DIV_RELOAD;
            w_rem_n   = w_mag;
            w_dir_n   = io_bus.movement[3];
          end
        end
      end
      RUN: begin
        w_div_n = r_div - DW'(1);
        if (r_div == '0) begin
          w_phase_n = r_dir ? r_phase - 2'd1 : r_phase + 2'd1;
          w_pos_n   = r_dir ? r_position - 8'd1 : r_position + 8'd1;
          w_rem_n   = r_rem - 4'd1;
          w_div_n   = DIV_RELOAD;
          if (r_rem == 4'd1 || io_bus.stop) begin
            w_state_n = SETTLE;
            w_rem_n   = 4'd0;
          end
        end else if (io_bus.stop) begin
          w_state_n = SETTLE;
          w_rem_n   = 4'd0;
          w_div_n   = DIV_RELOAD;
        end
      end
      SETTLE: begin
        w_div_n = r_div - DW'(1);
        if (r_div == '0) begin
          w_state_n = IDLE;
          w_done_n  = 1'b1;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_comb begin
    w_coils_n = phase_pattern(w_phase_n);
    if (w_state_n == IDLE) begin
`ifdef STEPPER_HOLD_EN
      w_coils_n = phase_pattern(w_phase_n);
`else
      w_coils_n = 4'b0000;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetN) begin
      r_state    <= IDLE;
      r_div      <= '0;
      r_rem      <= 4'd0;
      r_dir      <= 1'b0;
      r_phase    <= 2'd0;
      r_position <= 8'd0;
      r_coils    <= 4'b0000;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_div      <= w_div_n;
      r_rem      <= w_rem_n;
      r_dir      <= w_dir_n;
      r_phase    <= w_phase_n;
      r_position <= w_pos_n;
      r_coils    <= w_coils_n;
      r_busy     <= (w_state_n != IDLE);
      r_done     <= w_done_n;
    end
  end

  // Gated by reset so the source sees not-ready while reset is held.
  assign io_bus.cmdReady = (r_state == IDLE) && i_resetN;
  assign io_bus.coils    = r_coils;
  assign io_bus.busy     = r_busy;
  assign io_bus.done     = r_done;
  assign io_bus.position = r_position;

endmodule
